if_id_stage_reg: RTL and testbench

Parametrised IF/ID segment register for the RISC-V pipeline, wrapping a synchronous dual-port instruction memory. It registers PC, a generic prediction sideband and a valid bit, and aligns the one-cycle BRAM read with them. A three-state output controller gives a correct held instruction across multi-cycle stalls and a NOP bubble on flush. The block sits between the fetch PC register and the decode stage. A byte-writable debug port loads and inspects instruction memory.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/if_id_imem.sv | 40 ++++
 rtl/if_id_stage_reg.sv | 80 ++++++++
 tb/tb_if_id_stage_reg.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath width, bubble instruction,
// prediction sideband bit positions and the IF/ID output-controller states.
package pipe_pkg;

  localparam int unsigned XLEN         = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h00000013;
  localparam int unsigned SB_BTB_HIT   = 0;
  localparam int unsigned SB_BHT_TAKEN = 1;

  typedef enum logic [1:0] {
    BUBBLE = 2'd0,
    LIVE   = 2'd1,
    HOLD   = 2'd2
  } ostate_e;

endpackage

// File: rtl/if_id_imem.sv
// True dual-port read-first instruction RAM: port A read-only fetch,
// port B debug read with per-byte write enables.
module if_id_imem #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 12
) (
  input  logic            clk,
  input  logic [XLEN-1:0] addr_a,
  output logic [31:0]     rdata_a,
  input  logic [XLEN-1:0] addr_b,
  input  logic [31:0]     wdata_b,
  input  logic [3:0]      we_b,
  output logic [31:0]     rdata_b
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx_a;
  logic [AW-1:0] idx_b;
  logic          unused_addr_bits;

  // Word addressing; low byte-offset and high bits are dropped so accesses wrap.
  assign idx_a = addr_a[AW+1:2];
  assign idx_b = addr_b[AW+1:2];
  assign unused_addr_bits = ^{addr_a[XLEN-1:AW+2], addr_a[1:0],
                              addr_b[XLEN-1:AW+2], addr_b[1:0]};

  // Reads sample the array before this edge's write lands (read-first).
  always_ff @(posedge clk) begin
    rdata_a <= mem[idx_a];
    rdata_b <= mem[idx_b];
    for (int i = 0; i < 4; i++) begin
      if (we_b[i]) begin
        mem[idx_b][8*i +: 8] <= wdata_b[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/if_id_stage_reg.sv
// IF/ID segment register around the instruction RAM; keeps the decode
// instruction stable across stalls and injects a NOP bubble on flush.
module if_id_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN      = pipe_pkg::XLEN,
  parameter int unsigned IMEM_AW   = 12,
  parameter int unsigned SB_W      = 2,
  parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clear,
  input  logic [XLEN-1:0] addrF,
  input  logic [XLEN-1:0] pcF,
  input  logic [SB_W-1:0] sbF,
  input  logic            validF,
  output logic [XLEN-1:0] pcD,
  output logic [SB_W-1:0] sbD,
  output logic            validD,
  output logic [31:0]     instrD,
  input  logic [XLEN-1:0] dbg_addr,
  input  logic [31:0]     dbg_wdata,
  input  logic [3:0]      dbg_we,
  output logic [31:0]     dbg_rdata
);

  ostate_e     ostate;
  logic [31:0] ram_q;
  logic [31:0] hold_q;

  if_id_imem #(
    .XLEN (XLEN),
    .AW   (IMEM_AW)
  ) u_imem (
    .clk     (clk),
    .addr_a  (addrF),
    .rdata_a (ram_q),
    .addr_b  (dbg_addr),
    .wdata_b (dbg_wdata),
    .we_b    (dbg_we),
    .rdata_b (dbg_rdata)
  );

  // Output controller plus PC/sideband/valid segment registers.
  // The RAM keeps reading during a stall, so the shown word is parked in hold_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      ostate <= BUBBLE;
      hold_q <= NOP_INSTR;
      pcD    <= '0;
      sbD    <= '0;
      validD <= 1'b0;
    end else if (clear) begin
      ostate <= BUBBLE;
      pcD    <= '0;
      sbD    <= '0;
      validD <= 1'b0;
    end else if (en) begin
      ostate <= LIVE;
      pcD    <= pcF;
      sbD    <= sbF;
      validD <= validF;
    end else if (ostate == LIVE) begin
      ostate <= HOLD;
      hold_q <= ram_q;
    end
  end

  always_comb begin
    instrD = NOP_INSTR;
    case (ostate)
      LIVE:    instrD = ram_q;
      HOLD:    instrD = hold_q;
      default: instrD = NOP_INSTR;
    endcase
  end

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Bench for if_id_stage_reg: behavioural memory/pipeline model compared every
// cycle, plus directed literal checks of the documented scenarios.
module tb_if_id_stage_reg;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk;
  logic        rst;
  logic        en;
  logic        clear;
  logic [31:0] addrF;
  logic [31:0] pcF;
  logic [1:0]  sbF;
  logic        validF;
  logic [31:0] pcD;
  logic [1:0]  sbD;
  logic        validD;
  logic [31:0] instrD;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic [3:0]  dbg_we;
  logic [31:0] dbg_rdata;

  int checks = 0;
  int errors = 0;

  if_id_stage_reg #(
    .XLEN      (32),
    .IMEM_AW   (AW),
    .SB_W      (2),
    .NOP_INSTR (NOP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clear     (clear),
    .addrF     (addrF),
    .pcF       (pcF),
    .sbF       (sbF),
    .validF    (validF),
    .pcD       (pcD),
    .sbD       (sbD),
    .validD    (validD),
    .instrD    (instrD),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_we    (dbg_we),
    .dbg_rdata (dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: memory as a word array; decode slot either takes a new fetch,
  // becomes a bubble, or keeps exactly what it showed before.
  logic [31:0] mm [DEPTH];
  bit          mk [DEPTH];
  logic [31:0] e_pc, e_instr, e_dbg;
  logic [1:0]  e_sb;
  logic        e_valid;
  bit          e_ik, e_dk, mdl_ok;

  always @(posedge clk) begin
    int ia, ib;
    ia = int'((addrF / 32'd4) % 32'(DEPTH));
    ib = int'((dbg_addr / 32'd4) % 32'(DEPTH));
    e_dbg = mm[ib];
    e_dk  = mk[ib];
    if (rst || clear) begin
      e_pc = 32'd0; e_sb = 2'd0; e_valid = 1'b0; e_instr = NOP; e_ik = 1'b1;
    end else if (en) begin
      e_pc = pcF; e_sb = sbF; e_valid = validF; e_instr = mm[ia]; e_ik = mk[ia];
    end
    if (rst) mdl_ok = 1'b1;
    if (dbg_we == 4'hF) mk[ib] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (dbg_we[i]) mm[ib][8*i +: 8] = dbg_wdata[8*i +: 8];
    end
  end

  always @(negedge clk) begin
    if (mdl_ok) begin
      cmp("pcD", pcD, e_pc);
      cmp("sbD", 32'(sbD), 32'(e_sb));
      cmp("validD", 32'(validD), 32'(e_valid));
      if (e_ik) cmp("instrD", instrD, e_instr);
      if (e_dk) cmp("dbg_rdata", dbg_rdata, e_dbg);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'h00500093;
      1:       return 32'h00A00113;
      2:       return 32'h00F00193;
      3:       return 32'h11223344;
      default: return 32'hC0DE0000 | 32'(i);
    endcase
  endfunction

  task automatic fetch(input logic [31:0] a, input logic [1:0] sb, input logic v);
    addrF = a; pcF = a; sbF = sb; validF = v;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clear = 1'b0;
    addrF = '0; pcF = '0; sbF = '0; validF = 1'b0;
    dbg_addr = '0; dbg_wdata = '0; dbg_we = '0;
    #2;
    // Preload memory while reset is held.
    for (int i = 0; i < int'(DEPTH); i++) begin
      dbg_addr = 32'(i * 4); dbg_wdata = init_word(i); dbg_we = 4'hF;
      step();
    end
    dbg_we = 4'h0;
    step();
    step();
    cmp("lit_rst_pcD", pcD, 32'd0);
    cmp("lit_rst_validD", 32'(validD), 32'd0);
    cmp("lit_rst_sbD", 32'(sbD), 32'd0);
    cmp("lit_rst_instrD", instrD, 32'h00000013);

    // Sequential fetch.
    rst = 1'b0; en = 1'b1;
    fetch(32'd0, 2'b01, 1'b1);
    step();
    cmp("lit_seq0_instr", instrD, 32'h00500093);
    cmp("lit_seq0_pc", pcD, 32'd0);
    fetch(32'd4, 2'b10, 1'b1);
    step();
    cmp("lit_seq1_instr", instrD, 32'h00A00113);
    cmp("lit_seq1_pc", pcD, 32'd4);
    cmp("lit_seq1_sb", 32'(sbD), 32'd2);

    // Three-cycle stall with addrF moving underneath.
    en = 1'b0;
    fetch(32'd8, 2'b00, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      cmp("lit_stall_instr", instrD, 32'h00A00113);
      cmp("lit_stall_pc", pcD, 32'd4);
    end
    en = 1'b1;
    step();
    cmp("lit_resume_instr", instrD, 32'h00F00193);
    cmp("lit_resume_pc", pcD, 32'd8);

    // Flush while stalled.
    en = 1'b0; clear = 1'b1; sbF = 2'b11;
    step();
    cmp("lit_flush_instr", instrD, NOP);
    cmp("lit_flush_pc", pcD, 32'd0);
    cmp("lit_flush_sb", 32'(sbD), 32'd0);
    cmp("lit_flush_valid", 32'(validD), 32'd0);
    clear = 1'b0;

    // Byte write with same-cycle read-first on both ports.
    en = 1'b1;
    fetch(32'd12, 2'b00, 1'b1);
    step();
    cmp("lit_w3_instr", instrD, 32'h11223344);
    dbg_addr = 32'd12; dbg_wdata = 32'h0000AA00; dbg_we = 4'b0010;
    step();
    cmp("lit_bw_dbg_old", dbg_rdata, 32'h11223344);
    cmp("lit_bw_porta_old", instrD, 32'h11223344);
    dbg_we = 4'h0;
    step();
    cmp("lit_bw_porta_new", instrD, 32'h1122AA44);
    step();
    cmp("lit_bw_dbg_new", dbg_rdata, 32'h1122AA44);

    // Address wrap modulo depth.
    fetch(32'h40, 2'b00, 1'b1);
    step();
    cmp("lit_wrap_instr", instrD, 32'h00500093);

    // Reset in the middle of a stall clears the held word too.
    fetch(32'd4, 2'b01, 1'b1);
    step();
    en = 1'b0;
    fetch(32'd8, 2'b01, 1'b1);
    step();
    step();
    cmp("lit_hold_instr", instrD, 32'h00A00113);
    rst = 1'b1;
    step();
    cmp("lit_midrst_instr", instrD, NOP);
    rst = 1'b0;
    step();
    cmp("lit_postrst_stall_instr", instrD, NOP);
    cmp("lit_postrst_pc", pcD, 32'd0);

    // Mixed enable/flush pattern checked by the model.
    for (int i = 0; i < 24; i++) begin
      en       = (i % 4) != 3;
      clear    = (i == 9) || (i == 17);
      fetch(32'(i * 12), 2'(i), 1'(i % 2));
      dbg_addr = 32'(i * 20);
      step();
    end
    en = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
